// File: rtl/not_bank_filtered.sv
// Bank of WIDTH filtered channels: each one synchronised, glitch-filtered, then optionally inverted, with registered outputs.
// Optional macro NOT_BANK_CNT_EN enables the saturating filtered-event counter on evt_count.
module not_bank_filtered #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int FILT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  input  logic              cfg_we,
  input  logic [WIDTH-1:0]  cfg_mask,
  output logic [WIDTH-1:0]  dout,
  output logic [WIDTH-1:0]  changed,
  output logic [15:0]       evt_count
);

  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CYCLES - 1);

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  syn;
  logic [WIDTH-1:0]  filt_q;
  logic [WIDTH-1:0]  filt_d;
  logic [WIDTH-1:0]  filt_prev_q;
  logic [WIDTH-1:0]  mask_q;
  logic [FILT_W-1:0] cnt_q [WIDTH];
  logic [FILT_W-1:0] cnt_d [WIDTH];

  assign syn = sync_q[SYNC_STAGES-1];

  // The synchroniser runs every cycle; en only gates the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (en) begin
        if (syn[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = syn[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + FILT_W'(1);
        end
      end
    end
  end

  // changed compares filt with its one-cycle-old copy so the pulse lines up with the dout edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q      <= '0;
      filt_prev_q <= '0;
      mask_q      <= '1;
      dout        <= '1;
      changed     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      dout        <= filt_q ^ mask_q;
      changed     <= filt_q ^ filt_prev_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (cfg_we) begin
        mask_q <= cfg_mask;
      end
    end
  end

`ifdef NOT_BANK_CNT_EN
  logic [15:0] evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
    end else if ((|changed) && (evt_q != 16'hFFFF)) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign evt_count = evt_q;
`else
  assign evt_count = 16'h0000;
`endif

endmodule

// File: tb/tb_not_bank_filtered.sv
// Directed bench for not_bank_filtered: a per-cycle vector table for reset/latency/glitch behaviour,
// then hand sequences for mask writes, en gating, reset mid-filter and the event counter.
module tb_not_bank_filtered;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  din;
  logic        cfg_we;
  logic [7:0]  cfg_mask;
  logic [7:0]  dout;
  logic [7:0]  changed;
  logic [15:0] evt_count;

  int n_total = 0;
  int n_pass  = 0;
  int exp_evt = 0;

  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [7:0] exp_ch;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  not_bank_filtered dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .dout      (dout),
    .changed   (changed),
    .evt_count (evt_count)
  );

`ifdef NOT_BANK_CNT_EN
  logic        f_rst;
  logic [7:0]  f_din;
  logic [7:0]  f_dout;
  logic [7:0]  f_changed;
  logic [15:0] f_evt;

  not_bank_filtered #(.FILT_CYCLES(1)) u_fast (
    .clk       (clk),
    .rst       (f_rst),
    .en        (1'b1),
    .din       (f_din),
    .cfg_we    (1'b0),
    .cfg_mask  (8'h00),
    .dout      (f_dout),
    .changed   (f_changed),
    .evt_count (f_evt)
  );
`endif

  function automatic logic [15:0] evt_exp(input int v);
`ifdef NOT_BANK_CNT_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [7:0] d, input logic [7:0] ed, input logic [7:0] ec);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.exp_dout = ed;
    v.exp_ch = ec;
    tbl.push_back(v);
  endfunction

  // Drive a new level with en=1 and check the six-edge latency, the aligned changed pulse and the counter lag.
  task automatic settle(input string name, input logic [7:0] d, input logic [7:0] old_dout,
                        input logic [7:0] new_dout, input logic [7:0] ch);
    din = d;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 5) check({name, " hold"}, {8'h0, dout}, {8'h0, old_dout});
      if (e == 6) begin
        check({name, " dout"}, {8'h0, dout}, {8'h0, new_dout});
        check({name, " changed"}, {8'h0, changed}, {8'h0, ch});
        check({name, " evt before"}, evt_count, evt_exp(exp_evt));
      end
      if (e == 7) begin
        exp_evt++;
        check({name, " changed clear"}, {8'h0, changed}, 16'h0);
        check({name, " evt after"}, evt_count, evt_exp(exp_evt));
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = 8'h00; cfg_we = 1'b0; cfg_mask = 8'h00;
`ifdef NOT_BANK_CNT_EN
    f_rst = 1'b1; f_din = 8'h00;
`endif
    tick();
    check("reset evt_count", evt_count, 16'h0);

    // Reset with din=A5, then release: dout flips at the seventh edge after release (edge 6).
    add(1, 8'hA5, 8'hFF, 8'h00);
    add(1, 8'hA5, 8'hFF, 8'h00);
    for (int e = 0; e < 6; e++) add(0, 8'hA5, 8'hFF, 8'h00);
    add(0, 8'hA5, 8'h5A, 8'hA5);
    add(0, 8'hA5, 8'h5A, 8'h00);
    // Back to all-zero input.
    for (int e = 0; e < 6; e++) add(0, 8'h00, 8'h5A, 8'h00);
    add(0, 8'h00, 8'hFF, 8'hA5);
    add(0, 8'h00, 8'hFF, 8'h00);
    // Three-cycle pulse on channel 0 is rejected.
    for (int e = 0; e < 3; e++) add(0, 8'h01, 8'hFF, 8'h00);
    for (int e = 0; e < 7; e++) add(0, 8'h00, 8'hFF, 8'h00);
    // Four-cycle pulse passes: fall at edge 6, recover at edge 10.
    for (int e = 0; e < 4; e++) add(0, 8'h01, 8'hFF, 8'h00);
    add(0, 8'h00, 8'hFF, 8'h00);
    add(0, 8'h00, 8'hFF, 8'h00);
    add(0, 8'h00, 8'hFE, 8'h01);
    for (int e = 0; e < 3; e++) add(0, 8'h00, 8'hFE, 8'h00);
    add(0, 8'h00, 8'hFF, 8'h01);
    add(0, 8'h00, 8'hFF, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      din = tbl[i].din;
      tick();
      check($sformatf("tbl[%0d] dout", i), {8'h0, dout}, {8'h0, tbl[i].exp_dout});
      check($sformatf("tbl[%0d] changed", i), {8'h0, changed}, {8'h0, tbl[i].exp_ch});
    end
    exp_evt = 4;
    check("evt after table", evt_count, evt_exp(exp_evt));

    // Mask write: only dout moves, one edge after cfg_we.
    settle("din 0F", 8'h0F, 8'hFF, 8'hF0, 8'h0F);
    cfg_we = 1'b1; cfg_mask = 8'h00;
    tick();
    check("mask edge dout", {8'h0, dout}, 16'h00F0);
    check("mask edge changed", {8'h0, changed}, 16'h0);
    cfg_we = 1'b0;
    tick();
    check("mask applied dout", {8'h0, dout}, 16'h000F);
    check("mask applied changed", {8'h0, changed}, 16'h0);
    cfg_we = 1'b1; cfg_mask = 8'hFF;
    tick();
    cfg_we = 1'b0;
    tick();
    check("mask restored dout", {8'h0, dout}, 16'h00F0);

    // en low for 5 cycles mid-count pushes the update from edge 6 to edge 11.
    din = 8'hF0;
    for (int e = 0; e < 12; e++) begin
      en = !(e >= 3 && e <= 7);
      tick();
      check($sformatf("en gate e%0d dout", e), {8'h0, dout}, (e == 11) ? 16'h000F : 16'h00F0);
      if (e == 11) check("en gate changed", {8'h0, changed}, 16'h00FF);
    end
    en = 1'b1;
    tick();
    exp_evt++;
    check("en gate changed clear", {8'h0, changed}, 16'h0);
    check("en gate evt", evt_count, evt_exp(exp_evt));

    // Reset at cnt=2 discards the pending count; full latency applies after release.
    din = 8'hA5;
    for (int e = 0; e < 4; e++) tick();
    check("mid-filter pre-reset dout", {8'h0, dout}, 16'h000F);
    rst = 1'b1;
    tick();
    check("mid-filter reset dout", {8'h0, dout}, 16'h00FF);
    check("mid-filter reset changed", {8'h0, changed}, 16'h0);
    check("mid-filter reset evt", evt_count, 16'h0);
    exp_evt = 0;
    rst = 1'b0;
    settle("post-reset A5", 8'hA5, 8'hFF, 8'h5A, 8'hA5);

    // Two channels changing together count as one event each time.
    settle("two-ch 1", 8'hA6, 8'h5A, 8'h59, 8'h03);
    settle("two-ch 2", 8'hA5, 8'h59, 8'h5A, 8'h03);
    settle("two-ch 3", 8'hA6, 8'h5A, 8'h59, 8'h03);
    check("evt total", evt_count, evt_exp(4));

`ifdef NOT_BANK_CNT_EN
    // A single-cycle filter follows a toggling input every cycle, driving the counter into saturation.
    tick();
    f_rst = 1'b0;
    for (int c = 0; c < 65700; c++) begin
      f_din = ~f_din;
      tick();
    end
    check("evt saturate", f_evt, 16'hFFFF);
    f_din = ~f_din;
    tick();
    check("evt saturate hold", f_evt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
